thumb_fetch_queue: RTL

//  Instruction-fetch front end for the pipelined Thumb core, between the instruction memory port and decode.

---
 rtl/thumb_fetch_queue.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/thumb_fetch_queue.sv
// ---------------------------------------------------------------------------
// thumb_fetch_queue
//
// Instruction-fetch front end for the pipelined Thumb core. It sits between
// the instruction memory port and decode. It drives an active-low read strobe
// and a halfword address, and captures each 16-bit instruction together with
// its PC into a small FIFO. Decode takes entries from that FIFO over a
// valid/ready handshake. A branch redirect flushes the queue, aborts any
// in-flight access, and restarts fetch at the branch target.
//
// Parameters
//   DEPTH      FIFO entries (power of two, >= 2)
//   READ_WAIT  cycles imem_read_n is held low before imem_data is sampled
//   RESET_PC   first fetch address after reset
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   imem_read_n    instruction memory read strobe, active low
//   imem_addr      halfword fetch address (bit 0 always 0)
//   imem_data      instruction returned by memory
//   redirect_valid branch taken: flush and restart at redirect_addr
//   redirect_addr  branch target (bit 0 ignored)
//   halt           stop issuing new fetches; the queue still drains
//   out_valid      head entry valid
//   out_ready      decode consumes the head when out_valid && out_ready
//   out_instr      head instruction
//   out_pc         PC of the head instruction
//   stat_fetches   (THUMB_FETCH_STATS_EN only) completed accesses, saturating
//   stat_flushes   (THUMB_FETCH_STATS_EN only) redirects seen, saturating
//
// Build option: define THUMB_FETCH_STATS_EN to add the statistics counters.
// ---------------------------------------------------------------------------
module thumb_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter int          READ_WAIT = 1,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_read_n,
  output logic [31:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  input  logic        halt,
`ifdef THUMB_FETCH_STATS_EN
  output logic [31:0] stat_fetches,
  output logic [31:0] stat_flushes,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;  // extra bit tells full from empty after wrap
  localparam int WW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

  typedef enum logic {IDLE, READ} state_t;

  state_t         state;
  logic [WW-1:0]  wait_cnt;
  logic [31:0]    fetch_pc;

  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [15:0]    instr_mem [DEPTH];
  logic [31:0]    pc_mem    [DEPTH];

  logic           last_wait;
  logic           fetch_done;
  logic           push;
  logic           pop;
  logic [31:0]    redirect_pc;
  logic [PW-1:0]  count;
  logic [PW-1:0]  count_after;
  logic [PW-1:0]  wr_ptr_next;
  logic [PW-1:0]  rd_ptr_next;
  logic [PW-1:0]  count_next;
  logic [15:0]    head_instr;
  logic [31:0]    head_pc;
  logic           unused_addr_bit;

  assign unused_addr_bit = redirect_addr[0];
  assign redirect_pc     = {redirect_addr[31:1], 1'b0};

  // The address is simply the fetch PC register: it only moves when an access
  // completes or a redirect lands, so it is stable for the whole access.
  assign imem_addr  = fetch_pc;

  assign last_wait  = (wait_cnt == WW'(READ_WAIT - 1));
  assign fetch_done = (state == READ) && last_wait;
  // A redirect on the completing edge drops the data.
  assign push       = fetch_done && !redirect_valid;
  // A pop coinciding with a redirect is not a delivery.
  assign pop        = out_valid && out_ready && !redirect_valid;
  assign count      = wr_ptr - rd_ptr;
  // Occupancy once the current write and any pop have landed.
  assign count_after = count + PW'(1) - PW'(pop);

  // -------------------------------------------------------------------------
  // Fetch sequencer. A new access is only started when a slot is guaranteed
  // for its data, so the FIFO can never overflow.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      fetch_pc    <= {RESET_PC[31:1], 1'b0};
      imem_read_n <= 1'b1;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      wait_cnt <= '0;
      if (halt) begin
        state       <= IDLE;
        imem_read_n <= 1'b1;
      end else begin
        state       <= READ;
        imem_read_n <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (!halt && (count < PW'(DEPTH))) begin
            state       <= READ;
            wait_cnt    <= '0;
            imem_read_n <= 1'b0;
          end
        end
        READ: begin
          if (!last_wait) begin
            wait_cnt <= wait_cnt + WW'(1);
          end else begin
            fetch_pc <= fetch_pc + 32'd2;
            wait_cnt <= '0;
            if (!halt && (count_after < PW'(DEPTH))) begin
              state       <= READ;
              imem_read_n <= 1'b0;
            end else begin
              state       <= IDLE;
              imem_read_n <= 1'b1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          imem_read_n <= 1'b1;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FIFO storage (no reset needed: validity lives in the pointers).
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr[AW-1:0]] <= imem_data;
      pc_mem[wr_ptr[AW-1:0]]    <= fetch_pc;
    end
  end

  // Entry that will sit at the head after this edge. When that entry is the
  // one being written right now it is taken straight from the memory bus.
  always_comb begin
    wr_ptr_next = wr_ptr + PW'(push);
    rd_ptr_next = rd_ptr + PW'(pop);
    count_next  = wr_ptr_next - rd_ptr_next;
    if (push && (rd_ptr_next == wr_ptr)) begin
      head_instr = imem_data;
      head_pc    = fetch_pc;
    end else begin
      head_instr = instr_mem[rd_ptr_next[AW-1:0]];
      head_pc    = pc_mem[rd_ptr_next[AW-1:0]];
    end
  end

  // Pointers and registered head outputs. The head holds its last value
  // while the queue is empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else if (redirect_valid) begin
      rd_ptr    <= wr_ptr;
      out_valid <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      out_valid <= (count_next != '0);
      if (count_next != '0) begin
        out_instr <= head_instr;
        out_pc    <= head_pc;
      end
    end
  end

`ifdef THUMB_FETCH_STATS_EN
  // Completed accesses include those whose data a redirect dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_fetches <= '0;
      stat_flushes <= '0;
    end else begin
      if (fetch_done && (stat_fetches != 32'hFFFF_FFFF))
        stat_fetches <= stat_fetches + 32'd1;
      if (redirect_valid && (stat_flushes != 32'hFFFF_FFFF))
        stat_flushes <= stat_flushes + 32'd1;
    end
  end
`endif

endmodule
